bitmask_index_encoder: RTL and testbench

- Sequential encoder: the inverse direction of the gate-level binary decoder.
- Accepts an N-bit request mask and emits, one per handshake, the binary index of every set bit, lowest index first.
- Sits between a decoded one-hot/multi-hot request vector and binary-index consumers: arbiters, register-select logic, test harnesses that replay decoder outputs back to indices.

---
 rtl/bitmask_index_encoder_pkg.sv | 16 +
 rtl/bitmask_index_encoder_if.sv | 26 ++
 rtl/bitmask_index_encoder_lsb_priority_encoder.sv | 20 ++
 rtl/bitmask_index_encoder.sv | 74 +++++++
 tb/tb_bitmask_index_encoder.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bitmask_index_encoder_pkg.sv
// Shared types and helpers for the bitmask index encoder.
package bitmask_index_encoder_pkg;

  localparam int MAX_N = 64;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // True when the mask has zero or one bit set.
  function automatic logic at_most_one_set(input logic [MAX_N-1:0] m);
    return (m & (m - MAX_N'(1))) == '0;
  endfunction

endpackage

// File: rtl/bitmask_index_encoder_if.sv
// Mask-in / index-out handshake bundle for the bitmask index encoder.
interface bitmask_index_encoder_if #(
  parameter int N = 4
);
  localparam int IDX_W = $clog2(N);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_zero;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_zero
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_zero
  );

endinterface

// File: rtl/bitmask_index_encoder_lsb_priority_encoder.sv
// Combinational lowest-set-bit priority encoder.
module lsb_priority_encoder #(
  parameter int N = 4
) (
  input  logic [N-1:0]         mask,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IDX_W = $clog2(N);

  always_comb begin
    idx = '0;
    any = |mask;
    // Scan downward so the lowest set bit is the final assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bitmask_index_encoder.sv
// Captures an N-bit request mask and emits the index of each set bit,
// lowest first, one per output handshake.
module bitmask_index_encoder
  import bitmask_index_encoder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  bitmask_index_encoder_if.slave  bus,
  output logic                    busy
);
  localparam int IDX_W = $clog2(N);

  state_t           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic             zero_q, zero_d;
  logic [IDX_W-1:0] lsb_idx;
  logic             lsb_any;
  logic             emit;
  logic             last;

  lsb_priority_encoder #(.N(N)) u_lsb (
    .mask (pending_q),
    .idx  (lsb_idx),
    .any  (lsb_any)
  );

  assign emit = (state_q == EMIT);
  assign last = at_most_one_set(MAX_N'(pending_q));

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = emit;
  assign bus.out_idx   = (emit && lsb_any) ? lsb_idx : '0;
  assign bus.out_last  = emit && last;
  assign bus.out_zero  = emit && zero_q;
  assign busy          = emit;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pending_d = bus.a;
          zero_d    = (bus.a == '0);
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          // Drop the bit just emitted.
          pending_d = pending_q & (pending_q - N'(1));
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: tb/tb_bitmask_index_encoder.sv
// Self-checking bench: queue-based beat model plus directed literal checks.
module tb_bitmask_index_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bitmask_index_encoder_if #(.N(4)) bus4 ();
  bitmask_index_encoder_if #(.N(8)) bus8 ();
  logic busy4, busy8;

  bitmask_index_encoder #(.N(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus4),
    .busy (busy4)
  );

  bitmask_index_encoder #(.N(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus8),
    .busy (busy8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted mask becomes a list of expected beats.
  typedef struct {
    int idx;
    bit last;
    bit zero;
  } beat_t;

  beat_t q[$];

  task automatic push_mask(input logic [3:0] m);
    int hi;
    if (m == 4'd0) begin
      q.push_back('{0, 1'b1, 1'b1});
    end else begin
      hi = 0;
      for (int i = 0; i < 4; i++) if (m[i]) hi = i;
      for (int i = 0; i < 4; i++) if (m[i]) q.push_back('{i, (i == hi), 1'b0});
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else if (q.size() != 0) begin
      if (bus4.out_ready) void'(q.pop_front());
    end else if (bus4.in_valid) begin
      push_mask(bus4.a);
    end
    #1;
    chk("m_out_valid", 32'(bus4.out_valid), 32'(q.size() != 0));
    chk("m_in_ready", 32'(bus4.in_ready), 32'(q.size() == 0));
    chk("m_busy", 32'(busy4), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("m_out_idx", 32'(bus4.out_idx), 32'(q[0].idx));
      chk("m_out_last", 32'(bus4.out_last), 32'(q[0].last));
      chk("m_out_zero", 32'(bus4.out_zero), 32'(q[0].zero));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_until_idle(input string name);
    int n;
    n = 0;
    while (bus4.out_valid && n < 40) begin
      @(negedge clk);
      bus4.out_ready = ($urandom_range(0, 2) != 0);
      tick();
      n++;
    end
    if (n >= 40) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    bus4.in_valid = 1'b1;
    bus4.a = 4'b1111;
    bus4.out_ready = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.a = '0;
    bus8.out_ready = 1'b1;

    // Reset held two cycles while a mask is offered.
    repeat (2) begin
      tick();
      chk("rst_in_ready", 32'(bus4.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
      chk("rst_busy", 32'(busy4), 32'd0);
      chk("rst_out_idx", 32'(bus4.out_idx), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus4.in_valid = 1'b0;
    tick();
    chk("post_rst_idle", 32'(bus4.out_valid), 32'd0);

    // Multi-bit drain 1011 -> 0,1,3.
    @(negedge clk);
    bus4.in_valid = 1'b1; bus4.a = 4'b1011; bus4.out_ready = 1'b1;
    tick();
    chk("drain_b0_idx", 32'(bus4.out_idx), 32'd0);
    chk("drain_b0_last", 32'(bus4.out_last), 32'd0);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    tick();
    chk("drain_b1_idx", 32'(bus4.out_idx), 32'd1);
    chk("drain_b1_last", 32'(bus4.out_last), 32'd0);
    tick();
    chk("drain_b2_idx", 32'(bus4.out_idx), 32'd3);
    chk("drain_b2_last", 32'(bus4.out_last), 32'd1);
    tick();
    chk("drain_done_valid", 32'(bus4.out_valid), 32'd0);
    chk("drain_done_ready", 32'(bus4.in_ready), 32'd1);

    // Backpressure 0110: three stalled cycles on idx 1.
    @(negedge clk);
    bus4.in_valid = 1'b1; bus4.a = 4'b0110; bus4.out_ready = 1'b0;
    tick();
    chk("bp_stall0_idx", 32'(bus4.out_idx), 32'd1);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    repeat (2) begin
      tick();
      chk("bp_stall_idx", 32'(bus4.out_idx), 32'd1);
      chk("bp_stall_valid", 32'(bus4.out_valid), 32'd1);
    end
    @(negedge clk);
    bus4.out_ready = 1'b1;
    tick();
    chk("bp_b1_idx", 32'(bus4.out_idx), 32'd2);
    chk("bp_b1_last", 32'(bus4.out_last), 32'd1);
    tick();
    chk("bp_done", 32'(bus4.out_valid), 32'd0);

    // Zero mask: one beat flagged zero.
    @(negedge clk);
    bus4.in_valid = 1'b1; bus4.a = 4'b0000;
    tick();
    chk("zero_idx", 32'(bus4.out_idx), 32'd0);
    chk("zero_flag", 32'(bus4.out_zero), 32'd1);
    chk("zero_last", 32'(bus4.out_last), 32'd1);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    tick();
    chk("zero_done", 32'(bus4.out_valid), 32'd0);

    // Decoder loopback, one-hot masks.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus4.in_valid = 1'b1; bus4.a = 4'(1 << i);
      tick();
      chk("loop_idx", 32'(bus4.out_idx), 32'(i));
      chk("loop_last", 32'(bus4.out_last), 32'd1);
      @(negedge clk);
      bus4.in_valid = 1'b0;
      tick();
    end

    // N=8 top bit, then a two-bit mask spanning the full range.
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.a = 8'h80;
    tick();
    chk("n8_idx7", 32'(bus8.out_idx), 32'd7);
    chk("n8_last", 32'(bus8.out_last), 32'd1);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    tick();
    chk("n8_done", 32'(bus8.out_valid), 32'd0);
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.a = 8'h81;
    tick();
    chk("n8_81_b0", 32'(bus8.out_idx), 32'd0);
    chk("n8_81_b0_last", 32'(bus8.out_last), 32'd0);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    tick();
    chk("n8_81_b1", 32'(bus8.out_idx), 32'd7);
    chk("n8_81_b1_last", 32'(bus8.out_last), 32'd1);
    tick();

    // Mid-drain reset on 1111 after the second beat.
    @(negedge clk);
    bus4.in_valid = 1'b1; bus4.a = 4'b1111; bus4.out_ready = 1'b1;
    tick();
    chk("mdr_b0", 32'(bus4.out_idx), 32'd0);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    tick();
    chk("mdr_b1", 32'(bus4.out_idx), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("mdr_valid", 32'(bus4.out_valid), 32'd0);
    chk("mdr_ready", 32'(bus4.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0; bus4.in_valid = 1'b1; bus4.a = 4'b0100;
    tick();
    chk("mdr_next_idx", 32'(bus4.out_idx), 32'd2);
    chk("mdr_next_last", 32'(bus4.out_last), 32'd1);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    tick();
    chk("mdr_next_done", 32'(bus4.out_valid), 32'd0);

    // Every mask with irregular consumer backpressure, model-checked.
    for (int m = 0; m < 16; m++) begin
      @(negedge clk);
      bus4.in_valid = 1'b1; bus4.a = 4'(m); bus4.out_ready = 1'b0;
      tick();
      @(negedge clk);
      bus4.in_valid = 1'b0;
      bus4.a = 4'b1111;
      drain_until_idle("sweep");
      tick();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
